// File: rtl/cs_arb_pkg.sv
// Shared types and constants for the select-tree round-robin arbiter.
// Imported by the arbiter and the select decoder.
package cs_arb_pkg;

    localparam int N_REQ   = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 8;
    localparam int GUARD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    // Successor index, wrapping 7 back to 0.
    function automatic logic [IDX_W-1:0] next_idx(
        input logic [IDX_W-1:0] idx
    );
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/cs_rr_arbiter_decoder.sv
// 3-to-8 one-hot select decoder of the 5-to-32 select tree.
// All outputs are low while enable is low.
module decoder
    import cs_arb_pkg::*;
(
    input  logic [IDX_W-1:0] in,
    input  logic             enable,
    output logic [N_REQ-1:0] D
);

    // One output per index; only the addressed line rises when enabled.
    always_comb begin
        D = '0;
        for (int i = 0; i < N_REQ; i++) begin
            D[i] = enable & (in == IDX_W'(i));
        end
    end

endmodule

// File: rtl/cs_rr_arbiter.sv
// Round-robin owner arbiter for the shared select decoder.
// Break-before-make guard gaps and a per-ownership hold limit.
module cs_rr_arbiter
    import cs_arb_pkg::*;
#(
    parameter int MAX_HOLD  = 16,
    parameter int GUARD_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0]  LP_MAX_HOLD  = HOLD_W'(MAX_HOLD);
    localparam logic [GUARD_W-1:0] LP_GUARD_CYC = GUARD_W'(GUARD_CYC);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [N_REQ-1:0]   r_lockout;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_gnt_valid;
    logic               r_timeout;
    logic [HOLD_W-1:0]  r_hold;
    logic [GUARD_W-1:0] r_guard;

    logic [N_REQ-1:0]   w_elig;
    logic               w_win_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic               w_owner_req;
    logic               w_hold_max;
    logic               w_guard_done;
    logic               w_expire;
    logic [N_REQ-1:0]   w_lock_set;

    assign w_elig       = req & ~r_lockout;
    assign w_owner_req  = req[r_gnt_idx];
    assign w_hold_max   = (r_hold == LP_MAX_HOLD);
    assign w_guard_done = (r_guard == LP_GUARD_CYC);

    // Hold limit reached while the owner still wants the resource.
    assign w_expire = (r_state == GRANT) & w_owner_req & w_hold_max;

    // Priority scan starting at the pointer, first eligible wins.
    always_comb begin
        logic [IDX_W-1:0] v_cand;
        w_win_found = 1'b0;
        w_win_idx   = r_ptr;
        v_cand      = r_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            v_cand = r_ptr + IDX_W'(k);
            if (!w_win_found && w_elig[v_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = v_cand;
            end
        end
    end

    // Lockout bit to set for an owner reclaimed by the hold limit.
    always_comb begin
        w_lock_set = '0;
        if (w_expire) begin
            w_lock_set[r_gnt_idx] = 1'b1;
        end
    end

    // Lockout clears whenever the locked requester drops its request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lockout <= '0;
        end else begin
            r_lockout <= (r_lockout & req) | w_lock_set;
        end
    end

    // Ownership FSM with registered grant, counters and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold      <= '0;
            r_guard     <= '0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_win_found) begin
                        r_state     <= GRANT;
                        r_gnt_idx   <= w_win_idx;
                        r_gnt_valid <= 1'b1;
                        r_hold      <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (!w_owner_req) begin
                        r_state     <= GUARD;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= next_idx(r_gnt_idx);
                        r_guard     <= GUARD_W'(1);
                    end else if (w_hold_max) begin
                        r_state     <= GUARD;
                        r_gnt_valid <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_ptr       <= next_idx(r_gnt_idx);
                        r_guard     <= GUARD_W'(1);
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                GUARD: begin
                    if (w_guard_done) begin
                        r_state <= IDLE;
                    end else begin
                        r_guard <= r_guard + 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_gnt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

    // The decoder turns owner index and valid into the one-hot select.
    decoder u_dec (
        .in     (r_gnt_idx),
        .enable (r_gnt_valid),
        .D      (gnt)
    );

endmodule

// File: tb/tb_cs_rr_arbiter.sv
// Directed bench for cs_rr_arbiter (MAX_HOLD=16, GUARD_CYC=1).
// Table vectors plus hand sequences for round-robin, timeout and reset.
module tb_cs_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic       vld;
        logic [2:0] idx;
        logic       tmo;
    } vec_t;

    vec_t tbl[17];

    cs_rr_arbiter #(
        .MAX_HOLD  (16),
        .GUARD_CYC (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant must never select two lines at once.
    always @(negedge clk) begin
        if (rst_n) begin
            n_tests++;
            if ($countones(gnt) > 1) begin
                n_fail++;
                $display("FAIL onehot: got %0h expected at most one bit", gnt);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 8'h00;

        // single request 3, then pointer wrap between 7 and 0
        tbl[0]  = '{8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[1]  = '{8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[2]  = '{8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[3]  = '{8'h08, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[4]  = '{8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
        tbl[5]  = '{8'h00, 8'h00, 1'b0, 3'd3, 1'b0};
        tbl[6]  = '{8'h80, 8'h80, 1'b1, 3'd7, 1'b0};
        tbl[7]  = '{8'h80, 8'h80, 1'b1, 3'd7, 1'b0};
        tbl[8]  = '{8'h81, 8'h80, 1'b1, 3'd7, 1'b0};
        tbl[9]  = '{8'h01, 8'h00, 1'b0, 3'd7, 1'b0};
        tbl[10] = '{8'h81, 8'h00, 1'b0, 3'd7, 1'b0};
        tbl[11] = '{8'h81, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[12] = '{8'h80, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[13] = '{8'h80, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[14] = '{8'h80, 8'h80, 1'b1, 3'd7, 1'b0};
        tbl[15] = '{8'h00, 8'h00, 1'b0, 3'd7, 1'b0};
        tbl[16] = '{8'h00, 8'h00, 1'b0, 3'd7, 1'b0};

        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_vld", 32'(gnt_valid), 32'h0);
        check("rst_tmo", 32'(timeout), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        for (int v = 0; v < 17; v++) begin
            req = tbl[v].req;
            tick();
            check($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(tbl[v].gnt));
            check($sformatf("vec%0d_vld", v), 32'(gnt_valid), 32'(tbl[v].vld));
            check($sformatf("vec%0d_idx", v), 32'(gnt_idx), 32'(tbl[v].idx));
            check($sformatf("vec%0d_tmo", v), 32'(timeout), 32'(tbl[v].tmo));
        end

        // round robin: all request, owner drops after two cycles
        for (int k = 0; k < 9; k++) begin
            logic [7:0] exp_g;
            exp_g = 8'h01 << (k % 8);
            req = 8'hFF;
            tick();
            check($sformatf("rr%0d_c1", k), 32'(gnt), 32'(exp_g));
            tick();
            check($sformatf("rr%0d_c2", k), 32'(gnt), 32'(exp_g));
            req = 8'hFF & ~exp_g;
            tick();
            check($sformatf("rr%0d_rel", k), 32'(gnt), 32'h0);
            req = 8'hFF;
            tick();
            check($sformatf("rr%0d_gap", k), 32'(gnt), 32'h0);
        end

        // timeout: requester 2 never releases
        req = 8'h04;
        for (int c = 0; c < 16; c++) begin
            tick();
            check($sformatf("hold%0d_gnt", c), 32'(gnt), 32'h04);
            check($sformatf("hold%0d_tmo", c), 32'(timeout), 32'h0);
        end
        tick();
        check("to_gnt", 32'(gnt), 32'h0);
        check("to_pulse", 32'(timeout), 32'h1);
        tick();
        check("to_end", 32'(timeout), 32'h0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("lock%0d_gnt", c), 32'(gnt), 32'h0);
        end
        req = 8'h00;
        tick();
        check("unlock_gnt", 32'(gnt), 32'h0);

        // release exactly on the limit cycle
        req = 8'h04;
        tick();
        check("regrant", 32'(gnt), 32'h04);
        for (int c = 0; c < 15; c++) begin
            tick();
            check($sformatf("lim%0d_gnt", c), 32'(gnt), 32'h04);
        end
        req = 8'h00;
        tick();
        check("lim_rel_gnt", 32'(gnt), 32'h0);
        check("lim_rel_tmo", 32'(timeout), 32'h0);
        tick();
        check("lim_after_tmo", 32'(timeout), 32'h0);

        // reset mid-grant, pointer returns to 0
        req = 8'h20;
        tick();
        check("pre_rst_gnt", 32'(gnt), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_vld", 32'(gnt_valid), 32'h0);
        req = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req = 8'h01;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h01);
        check("post_rst_idx", 32'(gnt_idx), 32'h0);
        req = 8'h00;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
